// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a dual-port RAM: port 1 writes, port 2 reads.
// Owns the pointers, occupancy count, level flags and sticky error flags.
module ram_fifo_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 14,
  parameter int AF_LEVEL = (2**ADDR_W) - 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf,
  output logic [ADDR_W-1:0] addr1,
  output logic [DATA_W-1:0] data1,
  output logic              w_en1,
  output logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] data2,
  output logic              w_en2,
  input  logic [DATA_W-1:0] q2
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_ok, pop_ok;

  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign rd_valid    = rd_valid_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

  // Acceptance uses the pre-edge flags, so a pop never frees room for a push in the same cycle.
  assign push_ok = wr_en & ~full & ~rst;
  assign pop_ok  = rd_en & ~empty & ~rst;

  assign addr1   = wr_ptr_q;
  assign data1   = wr_data;
  assign w_en1   = push_ok;
  assign addr2   = rd_ptr_q;
  assign data2   = '0;
  assign w_en2   = 1'b0;
  assign rd_data = q2;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop_ok;
    ovf_d      = ovf_q | (wr_en & full);
    udf_d      = udf_q | (rd_en & empty);
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_ram_fifo_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst, wr_en, rd_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data, data1, data2, q2;
  logic              rd_valid, full, empty, almost_full, ovf, udf, w_en1, w_en2;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr1, addr2;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_en1) mem[addr1] <= data1;
    if (w_en2) mem[addr2] <= data2;
    q2 <= mem[addr2];
  end

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(DEPTH - 4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .ovf(ovf), .udf(udf),
    .addr1(addr1), .data1(data1), .w_en1(w_en1), .addr2(addr2),
    .data2(data2), .w_en2(w_en2), .q2(q2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_w_en2", w_en2, 0);
    chk("rst_data2", data2, 0);

    // three pushes then three pops
    wr_en = 1'b1; wr_data = 16'd20000; #1;
    chk("push0_w_en1", w_en1, 1);
    chk("push0_addr1", addr1, 0);
    chk("push0_data1", data1, 20000);
    cyc();
    wr_data = 16'd20123; #1;
    chk("push1_addr1", addr1, 1);
    cyc();
    wr_data = 16'd45;
    cyc();
    wr_en = 1'b0;
    chk("three_count", count, 3);
    chk("three_empty", empty, 0);
    rd_en = 1'b1; #1;
    chk("pop0_addr2", addr2, 0);
    cyc();
    chk("pop0_valid", rd_valid, 1);
    chk("pop0_data", rd_data, 20000);
    cyc();
    chk("pop1_valid", rd_valid, 1);
    chk("pop1_data", rd_data, 20123);
    cyc();
    rd_en = 1'b0;
    chk("pop2_valid", rd_valid, 1);
    chk("pop2_data", rd_data, 45);
    cyc();
    chk("drain3_valid", rd_valid, 0);
    chk("drain3_empty", empty, 1);
    chk("drain3_count", count, 0);
    chk("drain3_udf", udf, 0);

    // pop while empty
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("udf_valid", rd_valid, 0);
    chk("udf_set", udf, 1);
    chk("udf_count", count, 0);
    cyc();
    chk("udf_sticky", udf, 1);
    wr_en = 1'b1; wr_data = 16'd7;
    cyc();
    wr_en = 1'b0;
    chk("after_udf_count", count, 1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("after_udf_valid", rd_valid, 1);
    chk("after_udf_data", rd_data, 7);
    chk("after_udf_count0", count, 0);

    // simultaneous push/pop while empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'd867;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sim_empty_count", count, 1);
    chk("sim_empty_valid", rd_valid, 0);
    chk("sim_empty_udf", udf, 1);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("sim_empty_pop_valid", rd_valid, 1);
    chk("sim_empty_pop_data", rd_data, 867);

    // simultaneous push/pop at count 5
    wr_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = DATA_W'(i);
      cyc();
    end
    chk("five_count", count, 5);
    wr_data = 16'd6; rd_en = 1'b1;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sim5_count", count, 5);
    chk("sim5_valid", rd_valid, 1);
    chk("sim5_data", rd_data, 1);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_count", count, 0);
    chk("rst2_udf", udf, 0);
    chk("rst2_addr1", addr1, 0);

    // fill to full
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_data = DATA_W'(i);
      cyc();
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= DEPTH - 4) ? 1 : 0);
      chk("fill_full", full, (i + 1 == DEPTH) ? 1 : 0);
    end
    wr_data = 16'd999; #1;
    chk("ovf_w_en1", w_en1, 0);
    cyc();
    chk("ovf_count", count, DEPTH);
    chk("ovf_set", ovf, 1);
    chk("ovf_full", full, 1);
    chk("ovf_addr1", addr1, 0);

    // simultaneous push/pop while full
    wr_data = 16'd555; rd_en = 1'b1; #1;
    chk("sim_full_w_en1", w_en1, 0);
    cyc();
    wr_en = 1'b0;
    chk("sim_full_count", count, DEPTH - 1);
    chk("sim_full_ovf", ovf, 1);
    chk("sim_full_full", full, 0);
    chk("sim_full_valid", rd_valid, 1);
    chk("sim_full_data", rd_data, 0);

    for (int i = 1; i < DEPTH; i++) begin
      cyc();
      if (i == DEPTH - 1) rd_en = 1'b0;
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
    end
    cyc();
    chk("drained_empty", empty, 1);
    chk("drained_count", count, 0);
    chk("drained_valid", rd_valid, 0);
    chk("drained_ovf", ovf, 1);
    chk("drained_addr2", addr2, 0);

    // wrap-around across address DEPTH-1 -> 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH - 4; i++) begin
      wr_data = DATA_W'(i);
      cyc();
    end
    wr_en = 1'b0;
    chk("preload_count", count, DEPTH - 4);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH - 4; i++) begin
      cyc();
      if (i == DEPTH - 5) rd_en = 1'b0;
      chk("preload_data", rd_data, i);
    end
    chk("preload_empty", empty, 1);
    chk("preload_addr2", addr2, DEPTH - 4);
    wr_en = 1'b1; wr_data = 16'd100;
    cyc();
    for (int k = 1; k < 10; k++) begin
      wr_data = DATA_W'(100 + k); rd_en = 1'b1;
      cyc();
      chk("wrap_valid", rd_valid, 1);
      chk("wrap_data", rd_data, 100 + k - 1);
    end
    wr_en = 1'b0;
    cyc();
    rd_en = 1'b0;
    chk("wrap_last_data", rd_data, 109);
    chk("wrap_count", count, 0);
    chk("wrap_addr1", addr1, 6);
    chk("wrap_addr2", addr2, 6);

    // reset overriding push/pop at count 3
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    chk("pre_rst_udf", udf, 1);
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = DATA_W'(50 + i);
      cyc();
    end
    chk("pre_rst_count", count, 3);
    rd_en = 1'b1; rst = 1'b1; #1;
    chk("rst_cycle_w_en1", w_en1, 0);
    cyc();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_udf", udf, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_af", almost_full, 0);
    chk("mid_rst_addr1", addr1, 0);
    chk("mid_rst_addr2", addr2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
